// File: rtl/sdhci_cmd_serializer.sv
// SD host CMD line transmitter: shifts out a 48-bit command frame
// (start, transmission, index, argument, CRC7, end) paced by an SD-clock strobe,
// then holds the line idle-high for NccCycles strobes before accepting a new command.
module sdhci_cmd_serializer #(
    parameter int unsigned NccCycles = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        sd_strobe_i,
    input  logic        start_i,
    input  logic [5:0]  cmd_index_i,
    input  logic [31:0] cmd_arg_i,
    input  logic        abort_i,
    output logic        sd_cmd_o,
    output logic        sd_cmd_en_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam int unsigned GapW = (NccCycles > 1) ? $clog2(NccCycles) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'(NccCycles - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StGap
    } state_e;

    state_e          state_q, state_d;
    // Start + transmission bits are preloaded so b0..b39 all come from here.
    logic [39:0]     shift_q, shift_d;
    logic [6:0]      crc_q, crc_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic            cmd_q, cmd_d;
    logic            en_q, en_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // Next-state and output-register logic; abort overrides everything.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        cmd_d   = cmd_q;
        en_d    = en_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (abort_i) begin
            state_d = StIdle;
            shift_d = '0;
            crc_d   = '0;
            cnt_d   = '0;
            gap_d   = '0;
            cmd_d   = 1'b1;
            en_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    // A strobe in the acceptance cycle is ignored: we only reach SEND next cycle.
                    if (start_i && !busy_q) begin
                        shift_d = {2'b01, cmd_index_i, cmd_arg_i};
                        crc_d   = '0;
                        cnt_d   = '0;
                        gap_d   = '0;
                        busy_d  = 1'b1;
                        state_d = StSend;
                    end
                end
                StSend: begin
                    if (sd_strobe_i) begin
                        if (cnt_q < 6'd40) begin
                            cmd_d   = shift_q[39];
                            en_d    = 1'b1;
                            shift_d = {shift_q[38:0], 1'b0};
                            crc_d   = crc7_step(crc_q, shift_q[39]);
                            cnt_d   = cnt_q + 6'd1;
                        end else if (cnt_q < 6'd47) begin
                            // CRC register is shifted out MSB first, consuming it.
                            cmd_d = crc_q[6];
                            crc_d = {crc_q[5:0], 1'b0};
                            cnt_d = cnt_q + 6'd1;
                        end else if (cnt_q == 6'd47) begin
                            cmd_d = 1'b1;
                            cnt_d = cnt_q + 6'd1;
                        end else begin
                            cmd_d   = 1'b1;
                            en_d    = 1'b0;
                            done_d  = 1'b1;
                            gap_d   = '0;
                            state_d = StGap;
                        end
                    end
                end
                StGap: begin
                    if (sd_strobe_i) begin
                        if (gap_q == GapLast) begin
                            gap_d   = '0;
                            busy_d  = 1'b0;
                            state_d = StIdle;
                        end else begin
                            gap_d = gap_q + GapW'(1);
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    cmd_d   = 1'b1;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset releases the line immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            shift_q <= '0;
            crc_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            cmd_q   <= 1'b1;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            cmd_q   <= cmd_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sd_cmd_o    = cmd_q;
    assign sd_cmd_en_o = en_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule
